sfft_peak_finder: RTL and testbench

Downstream consumer of the SFFT pipeline's per-frame magnitude vector. On each new SFFT frame it snapshots all bins, scans them one bin per clock for local maxima, keeps the strongest peak in each of `NUM_BANDS` equal-width frequency bands, and publishes a frame-stamped peak set for the bus read-out logic. It replaces dumping the full spectrum to software with a compact fingerprint feed.

---
 rtl/sfft_peak_finder.sv | 141 ++++++++++++++
 tb/tb_sfft_peak_finder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sfft_peak_finder.sv
// Per-band strongest local-maximum finder over one SFFT magnitude frame, scanned one bin per clock.
// Optional macro PEAK_THRESHOLD_EN adds a `threshold` port that rejects peaks below it.
module sfft_peak_finder #(
  parameter  int NFFT       = 128,
  parameter  int AMP_WIDTH  = 32,
  parameter  int NUM_BANDS  = 4,
  parameter  int TIME_WIDTH = 32,
  localparam int IDX_W      = $clog2(NFFT)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NFFT*AMP_WIDTH-1:0]      sfft_bins,
  input  logic                           sfft_valid,
`ifdef PEAK_THRESHOLD_EN
  input  logic [AMP_WIDTH-1:0]           threshold,
`endif
  output logic [NUM_BANDS*IDX_W-1:0]     peak_bin,
  output logic [NUM_BANDS*AMP_WIDTH-1:0] peak_amp,
  output logic [TIME_WIDTH-1:0]          frame_count,
  output logic [7:0]                     dropped_count,
  output logic                           peaks_valid,
  output logic                           busy
);

  localparam int BAND_SHIFT = $clog2(NFFT / NUM_BANDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 2);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    sfft_valid_q;
  logic [TIME_WIDTH-1:0]   frame_q;
  logic [7:0]              drop_q;
  logic                    pv_q;
  logic [AMP_WIDTH-1:0]    snap_q [NFFT];

  logic                    frame_start, capture, drop;
  logic [AMP_WIDTH-1:0]    amp_prev, amp_cur, amp_next;
  logic                    thr_ok, is_peak;
  logic [IDX_W-1:0]        band_sel;

  assign frame_start = sfft_valid & ~sfft_valid_q;
  assign drop        = frame_start && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          capture = 1'b1;
          idx_d   = IDX_W'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sfft_valid_q <= 1'b0;
      frame_q      <= '0;
      drop_q       <= '0;
      pv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sfft_valid_q <= sfft_valid;
      pv_q         <= (state_q == COMMIT);
      if (state_q == COMMIT) frame_q <= frame_q + 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  // Snapshot content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NFFT; k++) snap_q[k] <= sfft_bins[k*AMP_WIDTH +: AMP_WIDTH];
    end
  end

  assign amp_prev = snap_q[idx_q - 1'b1];
  assign amp_cur  = snap_q[idx_q];
  assign amp_next = snap_q[idx_q + 1'b1];
`ifdef PEAK_THRESHOLD_EN
  assign thr_ok   = (amp_cur >= threshold);
`else
  assign thr_ok   = 1'b1;
`endif
  assign is_peak  = (state_q == SCAN) && (amp_cur > amp_prev) && (amp_cur >= amp_next) && thr_ok;
  assign band_sel = idx_q >> BAND_SHIFT;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
      logic [IDX_W-1:0]     wbin_q, obin_q;
      logic [AMP_WIDTH-1:0] wamp_q, oamp_q;

      // Strict compare keeps the lower bin on ties.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wbin_q <= '0;
          wamp_q <= '0;
          obin_q <= '0;
          oamp_q <= '0;
        end else begin
          if (capture) begin
            wbin_q <= '0;
            wamp_q <= '0;
          end else if (is_peak && band_sel == IDX_W'(gi) && amp_cur > wamp_q) begin
            wbin_q <= idx_q;
            wamp_q <= amp_cur;
          end
          if (state_q == COMMIT) begin
            obin_q <= wbin_q;
            oamp_q <= wamp_q;
          end
        end
      end

      assign peak_bin[gi*IDX_W +: IDX_W]         = obin_q;
      assign peak_amp[gi*AMP_WIDTH +: AMP_WIDTH] = oamp_q;
    end
  endgenerate

  assign frame_count   = frame_q;
  assign dropped_count = drop_q;
  assign peaks_valid   = pv_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sfft_peak_finder.sv
// Directed self-checking bench for sfft_peak_finder (NFFT=128, 4 bands of 32 bins).
module tb_sfft_peak_finder;

  localparam int NFFT = 128, AW = 32, NB = 4, TW = 32, IW = 7;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NFFT*AW-1:0]   sfft_bins = '0;
  logic                 sfft_valid = 1'b0;
  logic [AW-1:0]        threshold = '0;
  logic [NB*IW-1:0]     peak_bin;
  logic [NB*AW-1:0]     peak_amp;
  logic [TW-1:0]        frame_count;
  logic [7:0]           dropped_count;
  logic                 peaks_valid;
  logic                 busy;

  int n_assert = 0;
  int n_fail   = 0;

  sfft_peak_finder dut (
    .clk          (clk),
    .reset        (reset),
    .sfft_bins    (sfft_bins),
    .sfft_valid   (sfft_valid),
`ifdef PEAK_THRESHOLD_EN
    .threshold    (threshold),
`endif
    .peak_bin     (peak_bin),
    .peak_amp     (peak_amp),
    .frame_count  (frame_count),
    .dropped_count(dropped_count),
    .peaks_valid  (peaks_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic set_bin(input int k, input int v);
    sfft_bins[k*AW +: AW] = AW'(v);
  endtask

  task automatic check_band(input string tag, input int b, input int ebin, input int eamp);
    check({tag, "_bin"}, 64'(peak_bin[b*IW +: IW]), 64'(ebin));
    check({tag, "_amp"}, 64'(peak_amp[b*AW +: AW]), 64'(eamp));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pbin"}, 64'(peak_bin), 64'd0);
    check({tag, "_pamp"}, 64'(peak_amp), 64'd0);
    check({tag, "_fc"},   64'(frame_count), 64'd0);
    check({tag, "_drop"}, 64'(dropped_count), 64'd0);
    check({tag, "_pv"},   64'(peaks_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    sfft_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
  endtask

  // Capture one frame; optionally inject a second rise (with different bins) ov cycles after capture.
  task automatic run_frame(input string tag, input int ov);
    int n;
    n = 0;
    @(negedge clk);
    sfft_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    forever begin
      @(negedge clk);
      sfft_valid = (ov != 0 && n == ov);
      if (ov != 0 && n == ov) begin
        sfft_bins = '0;
        set_bin(50, 4000);
      end
      @(posedge clk);
      #1;
      n++;
      if (peaks_valid) break;
      if (n > 300) break;
    end
    check({tag, "_latency"}, 64'(n), 64'd127);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_pv_onecycle"}, 64'(peaks_valid), 64'd0);
  endtask

  initial begin
    int pulses;
    int fc0;

    #1;
    check_zero("por");
    reset = 1'b1;

    // Single tone
    do_reset();
    sfft_bins = '0;
    set_bin(10, 1000);
    run_frame("tone", 0);
    check_band("tone_b0", 0, 10, 1000);
    check_band("tone_b1", 1, 0, 0);
    check_band("tone_b2", 2, 0, 0);
    check_band("tone_b3", 3, 0, 0);
    check("tone_fc", 64'(frame_count), 64'd1);

    // Multi-band with tie
    sfft_bins = '0;
    set_bin(20, 500); set_bin(21, 500); set_bin(40, 300); set_bin(45, 700); set_bin(100, 50);
    run_frame("multi", 0);
    check_band("multi_b0", 0, 20, 500);
    check_band("multi_b1", 1, 45, 700);
    check_band("multi_b2", 2, 0, 0);
    check_band("multi_b3", 3, 100, 50);
    check("multi_fc", 64'(frame_count), 64'd2);

    // Edge bins never qualify
    sfft_bins = '0;
    set_bin(0, 9000); set_bin(127, 9000); set_bin(64, 5);
    run_frame("edge", 0);
    check_band("edge_b0", 0, 0, 0);
    check_band("edge_b1", 1, 0, 0);
    check_band("edge_b2", 2, 64, 5);
    check_band("edge_b3", 3, 0, 0);
    check("edge_fc", 64'(frame_count), 64'd3);

    // Overlapping frame is dropped and does not disturb the snapshot
    do_reset();
    sfft_bins = '0;
    set_bin(10, 1000);
    run_frame("ovl", 40);
    check("ovl_drop", 64'(dropped_count), 64'd1);
    check("ovl_fc", 64'(frame_count), 64'd1);
    check_band("ovl_b0", 0, 10, 1000);
    check_band("ovl_b1", 1, 0, 0);

    // sfft_valid held high yields a single capture
    fc0 = int'(frame_count);
    @(negedge clk);
    sfft_valid = 1'b1;
    repeat (300) @(negedge clk);
    sfft_valid = 1'b0;
    @(negedge clk);
    check("hold_fc", 64'(frame_count), 64'(fc0 + 1));
    check("hold_drop", 64'(dropped_count), 64'd1);

    // Reset mid-scan aborts the frame
    do_reset();
    sfft_bins = '0;
    set_bin(30, 999);
    @(negedge clk);
    sfft_valid = 1'b1;
    @(negedge clk);
    sfft_valid = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (peaks_valid) pulses++;
    end
    check_zero("mid_rst");
    reset = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (peaks_valid) pulses++;
    end
    check("mid_no_pulse", 64'(pulses), 64'd0);
    check("mid_fc0", 64'(frame_count), 64'd0);
    sfft_bins = '0;
    set_bin(5, 77);
    run_frame("mid_next", 0);
    check_band("mid_b0", 0, 5, 77);
    check("mid_fc", 64'(frame_count), 64'd1);

    // dropped_count saturates at 255
    do_reset();
    repeat (800) begin
      @(negedge clk);
      sfft_valid = ~sfft_valid;
    end
    sfft_valid = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check("sat_idle", 64'(busy), 64'd0);
    check("sat_drop", 64'(dropped_count), 64'd255);

`ifdef PEAK_THRESHOLD_EN
    do_reset();
    threshold = 100;
    sfft_bins = '0;
    set_bin(10, 99); set_bin(12, 100);
    run_frame("thr", 0);
    check_band("thr_b0", 0, 12, 100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
